// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and data-memory signals shared by the arbiter and its neighbours
interface dmem_arbiter_if #(
   parameter int WORD_LENGTH = 8,
   parameter int ADDR_LENGTH = 8
);
   logic                   cpu_read;
   logic                   cpu_write;
   logic [ADDR_LENGTH-1:0] cpu_addr;
   logic [WORD_LENGTH-1:0] cpu_wdata;
   logic [WORD_LENGTH-1:0] cpu_rdata;
   logic                   cpu_stall;
   logic                   dbg_req;
   logic                   dbg_we;
   logic [ADDR_LENGTH-1:0] dbg_addr;
   logic [WORD_LENGTH-1:0] dbg_wdata;
   logic                   dbg_valid;
   logic [WORD_LENGTH-1:0] dbg_rdata;
   logic [ADDR_LENGTH-1:0] mem_addr;
   logic [WORD_LENGTH-1:0] mem_wdata;
   logic                   mem_read;
   logic                   mem_write;
   logic [WORD_LENGTH-1:0] mem_rdata;
   modport slave (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      output cpu_rdata, cpu_stall, dbg_valid, dbg_rdata, mem_addr, mem_wdata, mem_read, mem_write
   );
   modport master (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      input  cpu_rdata, cpu_stall, dbg_valid, dbg_rdata, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences CPU and debug accesses onto the single-port data memory, stalling the pipeline
module dmem_arbiter #(
   parameter int WORD_LENGTH  = 8,
   parameter int ADDR_LENGTH  = 8,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic clk,
   input logic rst,
   dmem_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LATENCY + 1);
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [WW-1:0] wcnt, wcnt_n;
   logic          cpu_req, sat, gnt_dbg, gnt_cpu, cpu_act, dbg_act, last;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         wcnt          <= '0;
         bus.dbg_valid <= 1'b0;
         bus.dbg_rdata <= '0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         wcnt          <= wcnt_n;
         bus.dbg_valid <= dbg_act & last;
         if (dbg_act & last & ~bus.dbg_we) bus.dbg_rdata <= bus.mem_rdata;
      end
   end
   // the grant cycle is access cycle 0, so cnt is 0 in IDLE and last covers MEM_LATENCY==1 too
   always_comb begin
      cpu_req = bus.cpu_read | bus.cpu_write;
      sat     = wcnt == WW'(STARVE_LIMIT);
      gnt_dbg = state == IDLE && bus.dbg_req && (sat || !cpu_req);
      gnt_cpu = state == IDLE && cpu_req && !gnt_dbg;
      cpu_act = rst & (gnt_cpu | (state == CPU_ACC));
      dbg_act = rst & (gnt_dbg | (state == DBG_ACC));
      last    = cnt == CW'(MEM_LATENCY - 1);
      state_n = (cpu_act | dbg_act) & ~last ? (cpu_act ? CPU_ACC : DBG_ACC) : IDLE;
      cnt_n   = (cpu_act | dbg_act) & ~last ? cnt + CW'(1) : '0;
      wcnt_n  = (!bus.dbg_req || dbg_act) ? '0 : sat ? wcnt : wcnt + WW'(1);
   end
   assign bus.mem_addr  = cpu_act ? bus.cpu_addr : dbg_act ? bus.dbg_addr : '0;
   assign bus.mem_wdata = cpu_act ? bus.cpu_wdata : dbg_act ? bus.dbg_wdata : '0;
   assign bus.mem_read  = cpu_act ? ~bus.cpu_write : dbg_act & ~bus.dbg_we;
   assign bus.mem_write = last & (cpu_act ? bus.cpu_write : dbg_act & bus.dbg_we);
   assign bus.cpu_stall = rst & cpu_req & ~(cpu_act & last);
   assign bus.cpu_rdata = cpu_act & last ? bus.mem_rdata : '0;
endmodule
